game_loader: RTL and testbench

Receiving end of the ROM download byte stream. Consumes bytes strobed alongside a `downloading` flag, validates and strips a 16-byte cartridge header, and writes the payload sequentially into cartridge ROM through a single-port write interface. Sits between the ROM source (embedded image or external loader) and the cartridge ROM; `done` releases the console from reset.

---
 rtl/game_loader.sv | 185 ++++++++++++++++++
 tb/tb_game_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_loader.sv
// game_loader: receiving end of the ROM download byte stream.
// Validates a 16-byte cartridge header, strips it, and writes the payload
// sequentially into cartridge ROM. `done` releases the console from reset.
// Optional feature: define GAME_LOADER_CHECKSUM_EN to verify an 8-bit XOR of
// the payload against header byte 5 before declaring the image good.
module game_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              downloading,
  input  logic [7:0]        indata,
  input  logic              indata_clk,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              loading,
  output logic              done,
  output logic              error,
  output logic [7:0]        rom_kb
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PAYLOAD, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_t            r_state, w_next;
  logic              r_armed;      // downloading has been seen low since reset
  logic [3:0]        r_hcnt;
  logic [ADDR_W:0]   r_pcnt;       // one extra bit so a full-capacity count does not wrap
  logic [7:0]        r_rom_kb;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_data;
  logic              r_mem_we;
  logic              r_done;
  logic              r_error;

  logic              w_accept;
  logic              w_start;
  logic              w_hdr_byte;
  logic [3:0]        w_hidx;
  logic [7:0]        w_magic_exp;
  logic              w_magic_bad;
  logic [31:0]       w_size_bytes;
  logic              w_size_bad;
  logic              w_pay_byte;
  logic              w_pay_last;
  logic              w_sum_ok;

  assign w_accept     = indata_clk && downloading;
  // A download may only begin once the source has been seen idle since reset.
  assign w_start      = (r_state == S_IDLE) && downloading && r_armed;
  // The byte arriving in the entry cycle is header byte 0.
  assign w_hdr_byte   = w_accept && ((r_state == S_HEADER) || w_start);
  assign w_hidx       = (r_state == S_HEADER) ? r_hcnt : 4'd0;
  assign w_magic_bad  = (w_hidx < 4'd4) && (indata != w_magic_exp);
  assign w_size_bytes = {14'd0, r_rom_kb, 10'd0};
  assign w_size_bad   = (r_rom_kb == 8'd0) || (w_size_bytes > CAPACITY);
  assign w_pay_byte   = w_accept && (r_state == S_PAYLOAD);
  assign w_pay_last   = w_pay_byte &&
                        ((r_pcnt + (ADDR_W+1)'(1)) == w_size_bytes[ADDR_W:0]);

`ifdef GAME_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;
  logic [7:0] r_xor;
  // The final byte is folded in combinationally so the verdict lands with it.
  assign w_sum_ok = ((r_xor ^ indata) == r_csum);
`else
  assign w_sum_ok = 1'b1;
`endif

  // Expected magic byte for header positions 0..3.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    w_magic_exp = 8'h47;
    case (w_hidx[1:0])
      2'd1:    w_magic_exp = 8'h54;
      2'd2:    w_magic_exp = 8'h52;
      2'd3:    w_magic_exp = 8'h1A;
      default: w_magic_exp = 8'h47;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: truncation takes priority over any byte in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = (w_hdr_byte && w_magic_bad) ? S_ERROR : S_HEADER;
      end
      S_HEADER: begin
        if (!downloading)     w_next = S_ERROR;
        else if (w_accept) begin
          if (w_magic_bad)            w_next = S_ERROR;
          else if (r_hcnt == 4'd15)   w_next = w_size_bad ? S_ERROR : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!downloading)     w_next = S_ERROR;
        else if (w_pay_last)  w_next = w_sum_ok ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (!downloading) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, header capture, registered ROM write port and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_hcnt     <= '0;
      r_pcnt     <= '0;
      r_rom_kb   <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef GAME_LOADER_CHECKSUM_EN
      r_csum     <= '0;
      r_xor      <= '0;
`endif
    end else begin
      r_mem_we <= w_pay_byte;
      if (!downloading) r_armed <= 1'b1;

      if (r_state == S_IDLE) begin
        r_hcnt <= '0;
        r_pcnt <= '0;
      end

      if (w_start) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end

      if (w_hdr_byte) begin
        r_hcnt <= w_hidx + 4'd1;
        if (w_hidx == 4'd4) r_rom_kb <= indata;
`ifdef GAME_LOADER_CHECKSUM_EN
        if (w_hidx == 4'd5) r_csum <= indata;
`endif
      end

      if ((w_next == S_PAYLOAD) && (r_state != S_PAYLOAD)) begin
        r_pcnt <= '0;
`ifdef GAME_LOADER_CHECKSUM_EN
        r_xor  <= '0;
`endif
      end

      if (w_pay_byte) begin
        r_mem_addr <= r_pcnt[ADDR_W-1:0];
        r_mem_data <= indata;
        r_pcnt     <= r_pcnt + (ADDR_W+1)'(1);
`ifdef GAME_LOADER_CHECKSUM_EN
        r_xor      <= r_xor ^ indata;
`endif
      end

      if ((w_next == S_DONE)  && (r_state != S_DONE))  r_done  <= 1'b1;
      if ((w_next == S_ERROR) && (r_state != S_ERROR)) r_error <= 1'b1;
    end
  end

  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign loading  = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
  assign done     = r_done;
  assign error    = r_error;
  assign rom_kb   = r_rom_kb;

endmodule

// File: tb/tb_game_loader.sv
// Directed testbench for game_loader. Payload bytes follow a seeded pattern
// that the write monitor regenerates to check every ROM write.
module tb_game_loader;

  localparam int ADDR_W = 15;
  typedef logic [7:0] hdr_t [16];

  logic              clk = 1'b0;
  logic              reset;
  logic              downloading;
  logic [7:0]        indata;
  logic              indata_clk;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;
  logic              loading;
  logic              done;
  logic              error;
  logic [7:0]        rom_kb;

  int n_cmp = 0;
  int n_mis = 0;
  int n_writes = 0;
  int n_bad = 0;
  int wbase = 0;
  int bbase = 0;
  int seed = 0;
  logic pat_ones = 1'b0;

  game_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .downloading(downloading), .indata(indata),
    .indata_clk(indata_clk), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .loading(loading), .done(done), .error(error), .rom_kb(rom_kb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    if (pat_ones) return 8'h01;
    return 8'((i * 13) ^ (i >> 8) ^ seed);
  endfunction

  function automatic logic [7:0] calc_xor(input int n);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < n; i++) x = x ^ pat(i);
    return x;
  endfunction

  function automatic hdr_t make_hdr(input logic [7:0] kb, input logic [7:0] cs);
    hdr_t h;
    h = '{8'h47, 8'h54, 8'h52, 8'h1A, 8'h00, 8'h00, 8'hFF, 8'hFF,
          8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    h[4] = kb;
    h[5] = cs;
    return h;
  endfunction

  // Write monitor: each pulse must hit the next address with the next pattern byte.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (mem_addr !== ADDR_W'(n_writes - wbase) || mem_data !== pat(n_writes - wbase))
        n_bad = n_bad + 1;
      n_writes = n_writes + 1;
    end
  end

  task automatic strobe(input logic [7:0] b, input int gap);
    @(negedge clk);
    indata = b;
    indata_clk = 1'b1;
    repeat (gap) begin
      @(negedge clk);
      indata_clk = 1'b0;
    end
  endtask

  // Sends header bytes first..last; byte 0 raises downloading in the same cycle.
  task automatic send_hdr(input hdr_t h, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      if (i == 0) downloading = 1'b1;
      indata = h[i];
      indata_clk = 1'b1;
      repeat (gap) begin
        @(negedge clk);
        indata_clk = 1'b0;
      end
    end
  endtask

  task automatic end_dl();
    @(negedge clk);
    indata_clk = 1'b0;
    downloading = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    #1;
    wbase = n_writes;
    bbase = n_bad;
  endtask

  task automatic test_reset();
    reset = 1'b1; downloading = 1'b0; indata_clk = 1'b0; indata = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++; if ({mem_we, loading, done, error} !== 4'b0000) begin n_mis++; $display("FAIL reset_flags: got %b want 0000", {mem_we, loading, done, error}); end
    n_cmp++; if (mem_addr !== '0 || mem_data !== 8'h00 || rom_kb !== 8'h00) begin n_mis++; $display("FAIL reset_bus: got addr %h data %h kb %h want 0", mem_addr, mem_data, rom_kb); end
    reset = 1'b0;
  endtask

  // 24 KB image streamed back-to-back.
  task automatic test_valid_24k();
    seed = 5; pat_ones = 1'b0;
    mark();
    send_hdr(make_hdr(8'h18, calc_xor(24576)), 0, 15, 0);
    for (int i = 0; i < 24576; i++) begin
      strobe(pat(i), 0);
      if (i == 0) begin
        n_cmp++; if (loading !== 1'b1 || rom_kb !== 8'h18 || done !== 1'b0) begin n_mis++; $display("FAIL v24_payload_entry: got ld %b kb %h dn %b want 1 18 0", loading, rom_kb, done); end
      end
    end
    @(negedge clk); indata_clk = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || done !== 1'b1 || loading !== 1'b0) begin n_mis++; $display("FAIL v24_final: got we %b done %b ld %b want 1 1 0", mem_we, done, loading); end
    n_cmp++; if (mem_addr !== 15'd24575 || mem_data !== pat(24575)) begin n_mis++; $display("FAIL v24_last_write: got %h/%h want %h/%h", mem_addr, mem_data, 15'd24575, pat(24575)); end
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b0) begin n_mis++; $display("FAIL v24_we_pulse: got %b want 0", mem_we); end
    end_dl();
    n_cmp++; if (n_writes - wbase !== 24576 || n_bad - bbase !== 0) begin n_mis++; $display("FAIL v24_writes: got %0d writes %0d bad want 24576 0", n_writes - wbase, n_bad - bbase); end
    n_cmp++; if (done !== 1'b1 || error !== 1'b0 || rom_kb !== 8'h18) begin n_mis++; $display("FAIL v24_held: got done %b err %b kb %h want 1 0 18", done, error, rom_kb); end
  endtask

  task automatic test_bad_magic();
    hdr_t h;
    h = make_hdr(8'h01, 8'h00);
    h[2] = 8'h00;
    mark();
    send_hdr(h, 0, 1, 1);
    n_cmp++; if (done !== 1'b0 || error !== 1'b0 || loading !== 1'b1) begin n_mis++; $display("FAIL magic_pre: got dn %b err %b ld %b want 0 0 1", done, error, loading); end
    send_hdr(h, 2, 2, 1);
    n_cmp++; if (error !== 1'b1 || loading !== 1'b0) begin n_mis++; $display("FAIL magic_err: got err %b ld %b want 1 0", error, loading); end
    send_hdr(h, 3, 15, 1);
    for (int i = 0; i < 64; i++) strobe(8'hA5, 0);
    end_dl();
    n_cmp++; if (n_writes - wbase !== 0 || error !== 1'b1) begin n_mis++; $display("FAIL magic_nowrite: got %0d writes err %b want 0 1", n_writes - wbase, error); end
  endtask

  task automatic test_size(input logic [7:0] kb, input logic expect_err);
    hdr_t h;
    h = make_hdr(kb, 8'h00);
    mark();
    send_hdr(h, 0, 14, 0);
    n_cmp++; if (error !== 1'b0 || loading !== 1'b1) begin n_mis++; $display("FAIL size_%h_pre: got err %b ld %b want 0 1", kb, error, loading); end
    send_hdr(h, 15, 15, 1);
    n_cmp++; if (error !== expect_err || loading !== !expect_err) begin n_mis++; $display("FAIL size_%h_verdict: got err %b ld %b want %b %b", kb, error, loading, expect_err, !expect_err); end
    if (expect_err)
      for (int i = 0; i < 32; i++) strobe(8'h3C, 0);
    end_dl();
    n_cmp++; if (n_writes - wbase !== 0 || error !== 1'b1) begin n_mis++; $display("FAIL size_%h_end: got %0d writes err %b want 0 1", kb, n_writes - wbase, error); end
  endtask

  task automatic test_truncation();
    seed = 3; pat_ones = 1'b0;
    mark();
    send_hdr(make_hdr(8'h1C, 8'h00), 0, 15, 0);
    for (int i = 0; i < 1000; i++) strobe(pat(i), 1);
    @(negedge clk); downloading = 1'b0;
    @(negedge clk);
    n_cmp++; if (error !== 1'b1 || loading !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL trunc_err: got err %b ld %b dn %b want 1 0 0", error, loading, done); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (n_writes - wbase !== 1000 || n_bad - bbase !== 0 || error !== 1'b1) begin n_mis++; $display("FAIL trunc_writes: got %0d writes %0d bad err %b want 1000 0 1", n_writes - wbase, n_bad - bbase, error); end
  endtask

  // downloading falls in the same cycle as the final byte strobe.
  task automatic test_simultaneous();
    seed = 7; pat_ones = 1'b0;
    mark();
    send_hdr(make_hdr(8'h01, calc_xor(1024)), 0, 15, 0);
    for (int i = 0; i < 1023; i++) strobe(pat(i), 0);
    @(negedge clk); indata = pat(1023); indata_clk = 1'b1; downloading = 1'b0;
    @(negedge clk); indata_clk = 1'b0;
    n_cmp++; if (error !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0) begin n_mis++; $display("FAIL simul_err: got err %b dn %b we %b want 1 0 0", error, done, mem_we); end
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (n_writes - wbase !== 1023) begin n_mis++; $display("FAIL simul_writes: got %0d want 1023", n_writes - wbase); end
  endtask

  task automatic test_reset_mid();
    int wsnap;
    seed = 9; pat_ones = 1'b0;
    send_hdr(make_hdr(8'h01, calc_xor(1024)), 0, 15, 0);
    for (int i = 0; i < 300; i++) strobe(pat(i), 0);
    @(negedge clk); reset = 1'b1; indata = 8'h77;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({mem_we, loading, done, error} !== 4'b0000 || rom_kb !== 8'h00 || mem_addr !== '0) begin n_mis++; $display("FAIL rstmid_clear: got %b kb %h addr %h want 0000 00 0", {mem_we, loading, done, error}, rom_kb, mem_addr); end
    #1; wsnap = n_writes;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) strobe(8'h47, 0);
    n_cmp++; if (loading !== 1'b0 || n_writes !== wsnap) begin n_mis++; $display("FAIL rstmid_ignore: got ld %b writes %0d want 0 %0d", loading, n_writes, wsnap); end
    end_dl();
    seed = 11;
    mark();
    send_hdr(make_hdr(8'h01, calc_xor(1024)), 0, 15, 3);
    for (int i = 0; i < 1024; i++) strobe(pat(i), 3);
    end_dl();
    n_cmp++; if (n_writes - wbase !== 1024 || n_bad - bbase !== 0 || done !== 1'b1 || error !== 1'b0) begin n_mis++; $display("FAIL rstmid_fresh: got %0d writes %0d bad dn %b err %b want 1024 0 1 0", n_writes - wbase, n_bad - bbase, done, error); end
  endtask

  task automatic test_checksum(input logic [7:0] cs, input logic expect_err);
    pat_ones = 1'b1;
    mark();
    send_hdr(make_hdr(8'h01, cs), 0, 15, 0);
    for (int i = 0; i < 1024; i++) strobe(8'h01, 0);
    @(negedge clk); indata_clk = 1'b0;
    n_cmp++; if (mem_we !== 1'b1 || error !== expect_err || done !== !expect_err) begin n_mis++; $display("FAIL csum_%h_verdict: got we %b err %b dn %b want 1 %b %b", cs, mem_we, error, done, expect_err, !expect_err); end
    end_dl();
    n_cmp++; if (n_writes - wbase !== 1024 || n_bad - bbase !== 0) begin n_mis++; $display("FAIL csum_%h_writes: got %0d writes %0d bad want 1024 0", cs, n_writes - wbase, n_bad - bbase); end
    pat_ones = 1'b0;
  endtask

  initial begin
    test_reset();
    test_valid_24k();
    test_bad_magic();
    test_size(8'h21, 1'b1);
    test_size(8'h00, 1'b1);
    test_size(8'h20, 1'b0);
    test_truncation();
    test_simultaneous();
    test_reset_mid();
    test_checksum(8'h00, 1'b0);
`ifdef GAME_LOADER_CHECKSUM_EN
    test_checksum(8'h5A, 1'b1);
`else
    test_checksum(8'h5A, 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
